gf180mcu_fd_sc_mcu7t5v0__and2_arb: RTL and testbench
====================================================

# gf180mcu_fd_sc_mcu7t5v0__and2_arb

Round-robin arbiter that shares a single AND2 gating path among N requesters. Each requester presents an operand pair (A1[i], A2[i]) and a request; the arbiter registers a one-hot grant and drives Z = A1[sel] & A2[sel] for the granted lane only, with a bounded hold time so no requester can starve the others. It sits between the requester lanes and a shared gated-output net in the mcu7t5v0 library's functional models.

## Interface

Parameters:
- N, 4: number of requester lanes (2..8).
- HOLD_MAX, 8: maximum consecutive grant cycles while another lane is pending; 0 disables the cap.

Ports:
- CLK  input  1  rising-edge clock; sole clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  N  per-lane request, level-sensitive.
- A1  input  N  per-lane first operand.
- A2  input  N  per-lane second operand.
- GNT  output  N  registered one-hot grant (all-zero when idle).
- SEL  output  clog2(N)  registered binary index of granted lane.
- BUSY  output  1  registered; high when any grant is held.
- Z  output  1  A1[SEL] & A2[SEL] when BUSY, else 0 (combinational from registered SEL/BUSY and live A1/A2).
- VDD, VSS  inout  1  present only under USE_POWER_PINS; not used functionally.

## Operation

- Reset values (RST high at a CLK edge): GNT=0, SEL=0, BUSY=0, Z=0, rotate pointer PTR=0, hold counter CNT=0. RST overrides every other input, including mid-grant.
- States: IDLE (BUSY=0), OWN (BUSY=1, one lane granted).
- Priority search: scan lanes starting at PTR, ascending, wrapping mod N; the first lane with REQ high wins.
- IDLE: if any REQ high → OWN with winner granted, CNT=1, PTR=winner+1 mod N. Else stay IDLE.
- OWN, owner REQ low: release. If another lane requests, grant the next winner directly (no idle cycle), CNT=1, PTR updated; else → IDLE, GNT=0.
- OWN, owner REQ high, CNT==HOLD_MAX (HOLD_MAX≠0), another lane pending: forced rotation to next winner (search from PTR, which already excludes owner until wrap), CNT=1.
- OWN, owner REQ high, no other lane pending: keep grant; CNT saturates at HOLD_MAX (never wraps).
- OWN otherwise: keep grant, CNT=CNT+1.
- Single requester with N-way wrap: PTR wrap from N-1 to 0 is required.
- GNT always one-hot or zero; GNT[SEL]==BUSY.
- CNT width clog2(HOLD_MAX+1); with HOLD_MAX=0 CNT is held at 0 and no forced rotation occurs.
- A1/A2 of non-granted lanes never affect Z.

## Timing

- Grant latency: REQ[i] sampled high at edge t → GNT[i], SEL, BUSY valid after edge t (one cycle from assertion of REQ before edge t).
- Release latency: owner REQ sampled low at edge t → new grant or IDLE effective after edge t; owner holds the path exactly while its REQ is sampled high.
- Handover: zero bubble cycles between consecutive owners.
- Z: follows A1/A2 of the granted lane in the same cycle (no register); changes of SEL/BUSY occur only at CLK edges.
- Forced rotation: with continuous REQ on owner and a pending lane, owner holds exactly HOLD_MAX cycles.

## Test plan

- Reset: drive REQ=4'b1111, RST=1 for 2 cycles → GNT=0, SEL=0, BUSY=0, Z=0; release RST → next cycle GNT=4'b0001.
- Round-robin: REQ=4'b1111 held, each owner drops REQ for 1 cycle after granted → grant order 0,1,2,3,0 with no idle cycles.
- Hold cap: HOLD_MAX=8, REQ[2] continuous from cycle 0, REQ[0] raised at cycle 3 → GNT=4'b0100 for exactly 8 cycles, then 4'b0001.
- Solo owner: only REQ[3] high for 20 cycles → GNT=4'b1000 throughout, CNT saturates, no glitch to 0; then REQ[3] low → BUSY=0 next cycle.
- Datapath: lane 1 granted, A1=4'b0010, A2=4'b0010 → Z=1; set A2[1]=0 → Z=0 same cycle; toggle A1/A2 of lanes 0,2,3 → Z unchanged.
- Reset mid-grant: lane 2 owning, CNT=5, RST=1 one cycle → all outputs zero, PTR=0; REQ=4'b0110 after reset → lane 1 granted first.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and2_arb.sv
// Round-robin arbiter sharing one AND2 gating path among N requester lanes.
// Registered one-hot grant with a bounded hold; Z gates only the granted lane's operands.
module gf180mcu_fd_sc_mcu7t5v0__and2_arb #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         A1,
  input  logic [N-1:0]         A2,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] SEL,
  output logic                 BUSY,
  output logic                 Z
);

  localparam int SW = $clog2(N);
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(HOLD_MAX);
  localparam logic [CW-1:0] C_ONE = (HOLD_MAX > 0) ? CW'(1) : '0;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_gnt, w_gnt_nx;
  logic [SW-1:0] r_sel, w_sel_nx;
  logic [SW-1:0] r_ptr, w_ptr_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [N-1:0]  w_others;
  logic          w_owner_req;
  logic          w_found;
  logic [SW-1:0] w_win;
  logic          w_grant_new;

  // First requesting lane at or after ptr, wrapping mod N; MSB flags a hit.
  function automatic logic [SW:0] f_search(input logic [N-1:0] mask, input logic [SW-1:0] ptr);
    logic          found;
    logic [SW-1:0] win;
    logic [SW-1:0] idx;
    int            j;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = SW'(j);
      if (!found && mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [SW-1:0] f_inc_mod(input logic [SW-1:0] v);
    return (int'(v) == N - 1) ? '0 : v + SW'(1);
  endfunction

  function automatic logic [N-1:0] f_onehot(input logic [SW-1:0] s);
    logic [N-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  assign w_others    = REQ & ~r_gnt;
  assign w_owner_req = |(REQ & r_gnt);
  assign {w_found, w_win} = f_search(w_others, r_ptr);

  always_comb begin
    w_state_nx  = r_state;
    w_gnt_nx    = r_gnt;
    w_sel_nx    = r_sel;
    w_ptr_nx    = r_ptr;
    w_cnt_nx    = r_cnt;
    w_grant_new = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_grant_new = 1'b1;
      end
      S_OWN: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_grant_new = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = '0;
            w_sel_nx   = '0;
            w_cnt_nx   = '0;
          end
        end else if ((HOLD_MAX != 0) && (r_cnt == C_MAX) && w_found) begin
          w_grant_new = 1'b1;
        end else if (r_cnt < C_MAX) begin
          // Counter saturates so a lone owner never wraps back into a short hold.
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_grant_new) begin
      w_state_nx = S_OWN;
      w_gnt_nx   = f_onehot(w_win);
      w_sel_nx   = w_win;
      w_ptr_nx   = f_inc_mod(w_win);
      w_cnt_nx   = C_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_sel   <= w_sel_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign GNT  = r_gnt;
  assign SEL  = r_sel;
  assign BUSY = (r_state == S_OWN);
  assign Z    = BUSY & A1[r_sel] & A2[r_sel];

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__and2_arb.sv
// Directed bench for the AND2 round-robin arbiter; expectations queued at drive time, checked after each edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__and2_arb;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] A1;
  logic [3:0] A2;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       BUSY;
  logic       Z;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       z;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__and2_arb #(.N(4), .HOLD_MAX(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .A1   (A1),
    .A2   (A2),
    .GNT  (GNT),
    .SEL  (SEL),
    .BUSY (BUSY),
    .Z    (Z)
  );

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic push(input string tag, input logic [3:0] g);
    exp_t e;
    e.tag  = tag;
    e.gnt  = g;
    e.sel  = idx_of(g);
    e.busy = |g;
    e.z    = (|g) & A1[e.sel] & A2[e.sel];
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    assert ({GNT, SEL, BUSY, Z} === {e.gnt, e.sel, e.busy, e.z}) else begin
      n_bad++;
      $error("FAIL %s: observed gnt=%b sel=%0d busy=%b z=%b, expected gnt=%b sel=%0d busy=%b z=%b",
             e.tag, GNT, SEL, BUSY, Z, e.gnt, e.sel, e.busy, e.z);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] g);
    REQ = req;
    push(tag, g);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  task automatic chk_z(input string tag, input logic ez);
    #1;
    n_vec++;
    assert (Z === ez) else begin
      n_bad++;
      $error("FAIL %s: observed z=%b, expected z=%b", tag, Z, ez);
    end
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    A1  = 4'b1111;
    A2  = 4'b1111;

    // reset dominates a full request vector
    cyc("rst0", 4'b1111, 4'b0000);
    cyc("rst1", 4'b1111, 4'b0000);
    RST = 1'b0;

    // round robin, each owner drops its request once granted
    cyc("rr0", 4'b1111, 4'b0001);
    cyc("rr1", 4'b1110, 4'b0010);
    cyc("rr2", 4'b1101, 4'b0100);
    cyc("rr3", 4'b1011, 4'b1000);
    cyc("rr4", 4'b0111, 4'b0001);
    cyc("rr_idle", 4'b0000, 4'b0000);

    // hold cap: lane 2 continuous, lane 0 joins on the third cycle
    for (int i = 1; i <= 8; i++)
      cyc($sformatf("hold%0d", i), (i < 3) ? 4'b0100 : 4'b0101, 4'b0100);
    cyc("hold_rot", 4'b0101, 4'b0001);
    cyc("hold_idle", 4'b0000, 4'b0000);

    // solo owner, counter saturates without dropping the grant
    for (int i = 0; i < 20; i++)
      cyc($sformatf("solo%0d", i), 4'b1000, 4'b1000);
    cyc("solo_rel", 4'b0000, 4'b0000);

    // saturated owner yields at once when another lane arrives
    for (int i = 0; i < 10; i++)
      cyc($sformatf("sat%0d", i), 4'b1000, 4'b1000);
    cyc("sat_rot", 4'b1001, 4'b0001);
    cyc("sat_idle", 4'b0000, 4'b0000);

    // datapath through lane 1
    A1 = 4'b0010;
    A2 = 4'b0010;
    cyc("dp_gnt", 4'b0010, 4'b0010);
    A2 = 4'b0000;
    chk_z("dp_a2lo", 1'b0);
    A2 = 4'b0010;
    chk_z("dp_a2hi", 1'b1);
    A1 = 4'b1111;
    A2 = 4'b1111;
    chk_z("dp_others_hi", 1'b1);
    A1 = 4'b1101;
    chk_z("dp_a1lo", 1'b0);
    A1 = 4'b0111;
    A2 = 4'b1010;
    cyc("dp_hold", 4'b0010, 4'b0010);
    A1 = 4'b0010;
    A2 = 4'b0000;
    chk_z("dp_a2lo2", 1'b0);
    A1 = 4'b1111;
    A2 = 4'b1111;
    cyc("dp_idle", 4'b0000, 4'b0000);

    // reset in the middle of a grant
    cyc("mg0", 4'b0100, 4'b0100);
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("mg%0d", i), 4'b0100, 4'b0100);
    RST = 1'b1;
    cyc("mg_rst", 4'b0100, 4'b0000);
    RST = 1'b0;
    cyc("mg_after", 4'b0110, 4'b0010);
    cyc("mg_idle", 4'b0000, 4'b0000);

    // rotate pointer returns to lane 0 after reset
    cyc("ptr_own", 4'b0100, 4'b0100);
    RST = 1'b1;
    cyc("ptr_rst", 4'b0100, 4'b0000);
    RST = 1'b0;
    cyc("ptr_chk", 4'b1001, 4'b0001);
    cyc("end_idle", 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
